// File: rtl/debounced_buttons_bus_interface.sv
// rtl/debounced_buttons_bus_interface.sv - debounced button channels with edge IRQs behind a bus slave window
//
// Purpose: CHANNELS button inputs, each synchronised (2 FF) and counter
// debounced. Per-channel edge modes log events into sticky W1C pending
// flags. Per-channel level IRQs are formed from the pending flags and the
// enable register. Everything sits behind a 16-byte register window.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   btns           raw asynchronous button levels
//   irqs           level interrupt per channel (pending & enable)
//   addr_bus       bus byte address
//   data_bus       bus data, driven only during a read hit
//   rd_bus         read strobe
//   wr_bus         write strobe
//   data_mask_bus  byte-lane write enables
//   fc_bus         function complete, driven only on an address hit
//
// Register map (word offset from START_ADDR):
//   0 ENABLE (RW), 1 MODE (RW, 2 bits/channel), 2 LEVEL (RO), 3 PENDING (W1C)

module debounced_buttons_bus_interface #(
  parameter logic [31:0] START_ADDR      = 32'h0,
  parameter int          CHANNELS        = 4,
  parameter int          DEBOUNCE_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] btns,
  output logic [CHANNELS-1:0] irqs,
  input  logic [31:0]         addr_bus,
  inout  wire  [31:0]         data_bus,
  input  logic                rd_bus,
  input  logic                wr_bus,
  input  logic [3:0]          data_mask_bus,
  output wire                 fc_bus
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [32:0]    WIN_LO   = {1'b0, START_ADDR};
  localparam logic [32:0]    WIN_HI   = WIN_LO + 33'd16;

  typedef enum logic {S_IDLE, S_DONE} state_t;

  logic [CHANNELS-1:0]   sync1, sync2, deb;
  logic [CW-1:0]         cnt [CHANNELS];
  logic [CHANNELS-1:0]   enable, pending, ev, clr;
  logic [2*CHANNELS-1:0] mode;
  state_t                state, state_next;
  logic                  hit, commit, fc_drive;
  logic [1:0]            word;
  logic [31:0]           wmask, rdata;
  logic                  unused_bits;

  // 33-bit compare so a window at the top of the address space cannot wrap.
  assign hit  = ({1'b0, addr_bus} >= WIN_LO) && ({1'b0, addr_bus} < WIN_HI);
  assign word = addr_bus[3:2] - START_ADDR[3:2];
  assign wmask = {{8{data_mask_bus[3]}}, {8{data_mask_bus[2]}},
                  {8{data_mask_bus[1]}}, {8{data_mask_bus[0]}}};
  assign unused_bits = ^{data_bus, wmask};

  // Synchroniser and debouncer.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
    end else begin
      sync1 <= btns;
      sync2 <= sync1;
      for (int i = 0; i < CHANNELS; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // An event fires on the same edge the debounced level flips.
  always_comb begin
    ev = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sync2[i] != deb[i] && cnt[i] == CNT_LAST) begin
        ev[i] = sync2[i] ? mode[2*i] : mode[2*i+1];
      end
    end
  end

  // Write handshake: commit once on entry to DONE, stay until the strobe drops.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    commit     = 1'b0;
    case (state)
      S_IDLE: begin
        if (hit && wr_bus) begin
          commit     = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (!(hit && wr_bus)) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign fc_drive = rd_bus || (state == S_DONE && wr_bus);
  assign clr = (commit && word == 2'd3) ? (data_bus[CHANNELS-1:0] & wmask[CHANNELS-1:0]) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      enable  <= '0;
      mode    <= '0;
      pending <= '0;
    end else begin
      if (commit && word == 2'd0)
        enable <= (enable & ~wmask[CHANNELS-1:0]) | (data_bus[CHANNELS-1:0] & wmask[CHANNELS-1:0]);
      if (commit && word == 2'd1)
        mode <= (mode & ~wmask[2*CHANNELS-1:0]) | (data_bus[2*CHANNELS-1:0] & wmask[2*CHANNELS-1:0]);
      // A new event wins over a simultaneous clear of the same bit.
      pending <= (pending & ~clr) | ev;
    end
  end

  always_comb begin
    rdata = '0;
    case (word)
      2'd0:    rdata[CHANNELS-1:0]   = enable;
      2'd1:    rdata[2*CHANNELS-1:0] = mode;
      2'd2:    rdata[CHANNELS-1:0]   = deb;
      default: rdata[CHANNELS-1:0]   = pending;
    endcase
  end

  assign irqs     = pending & enable;
  assign data_bus = (hit && rd_bus) ? rdata : 'z;
  assign fc_bus   = hit ? fc_drive : 1'bz;

endmodule

// File: tb/tb_debounced_buttons_bus_interface.sv
// tb/tb_debounced_buttons_bus_interface.sv - self-checking bench for debounced_buttons_bus_interface
module tb_debounced_buttons_bus_interface;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int          CH   = 4;
  localparam int          DB   = 4;
  localparam logic [31:0] A_EN = BASE;
  localparam logic [31:0] A_MD = BASE + 32'h4;
  localparam logic [31:0] A_LV = BASE + 32'h8;
  localparam logic [31:0] A_PD = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  btns;
  logic [3:0]  irqs;
  logic [31:0] addr_bus;
  tri1  [31:0] data_bus;
  logic        rd_bus, wr_bus;
  logic [3:0]  data_mask_bus;
  tri0         fc_bus;
  logic        drive_en;
  logic [31:0] wdata;

  int checks = 0;
  int errors = 0;

  assign data_bus = drive_en ? wdata : 'z;
  always #5 clk = ~clk;

  debounced_buttons_bus_interface #(
    .START_ADDR(BASE), .CHANNELS(CH), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk), .rst(rst), .btns(btns), .irqs(irqs),
    .addr_bus(addr_bus), .data_bus(data_bus), .rd_bus(rd_bus), .wr_bus(wr_bus),
    .data_mask_bus(data_mask_bus), .fc_bus(fc_bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pins reach the debouncer two edges late; the level
  // flips after DB consecutive differing samples; writes land once per strobe.
  logic [3:0] m_p1 = '0, m_p2 = '0, m_deb = '0, m_en = '0, m_pend = '0;
  logic [7:0] m_mode = '0;
  int         m_run [4] = '{0, 0, 0, 0};
  logic       m_prev_hw = 1'b0;

  function automatic logic in_win(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'd16);
  endfunction

  function automatic logic [31:0] model_reg(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    case (off[3:2])
      2'd0:    return {28'd0, m_en};
      2'd1:    return {24'd0, m_mode};
      2'd2:    return {28'd0, m_deb};
      default: return {28'd0, m_pend};
    endcase
  endfunction

  initial forever begin
    logic [3:0]  ev, clr;
    logic [31:0] mask, off;
    @(posedge clk);
    if (rst) begin
      m_p1 = '0; m_p2 = '0; m_deb = '0; m_en = '0; m_pend = '0; m_mode = '0;
      m_prev_hw = 1'b0;
      for (int i = 0; i < CH; i++) m_run[i] = 0;
    end else begin
      ev = '0;
      for (int i = 0; i < CH; i++) begin
        if (m_p2[i] != m_deb[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DB) begin
            m_deb[i] = m_p2[i];
            m_run[i] = 0;
            ev[i] = m_deb[i] ? m_mode[2*i] : m_mode[2*i+1];
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_p2 = m_p1;
      m_p1 = btns;
      clr = '0;
      if (in_win(addr_bus) && wr_bus && !m_prev_hw) begin
        mask = {{8{data_mask_bus[3]}}, {8{data_mask_bus[2]}}, {8{data_mask_bus[1]}}, {8{data_mask_bus[0]}}};
        off = addr_bus - BASE;
        case (off[3:2])
          2'd0: m_en = (m_en & ~mask[3:0]) | (wdata[3:0] & mask[3:0]);
          2'd1: m_mode = (m_mode & ~mask[7:0]) | (wdata[7:0] & mask[7:0]);
          2'd3: clr = wdata[3:0] & mask[3:0];
          default: ;
        endcase
      end
      m_pend = (m_pend & ~clr) | ev;
      m_prev_hw = in_win(addr_bus) && wr_bus;
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial forever begin
    logic h;
    @(negedge clk);
    h = in_win(addr_bus);
    chk("irqs", {28'd0, irqs}, {28'd0, m_pend & m_en});
    chk("fc_bus", {31'd0, fc_bus}, {31'd0, h && (rd_bus || (wr_bus && m_prev_hw))});
    if (rd_bus)
      chk("data_bus", data_bus, h ? model_reg(addr_bus) : 32'hFFFF_FFFF);
    else if (!drive_en)
      chk("data_bus_idle", data_bus, 32'hFFFF_FFFF);
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, input int hold);
    @(posedge clk); #1;
    addr_bus = a; wdata = d; data_mask_bus = m; drive_en = 1'b1; wr_bus = 1'b1;
    repeat (hold) @(posedge clk);
    #1; wr_bus = 1'b0; drive_en = 1'b0;
  endtask

  task automatic bus_read(input string name, input logic [31:0] a, input logic [31:0] exp);
    @(posedge clk); #1;
    addr_bus = a; rd_bus = 1'b1;
    @(negedge clk);
    chk(name, data_bus, exp);
    chk({name, "_fc"}, {31'd0, fc_bus}, 32'd1);
    @(posedge clk); #1;
    rd_bus = 1'b0;
  endtask

  initial begin
    rst = 1'b1; btns = '0; addr_bus = BASE; rd_bus = 1'b0; wr_bus = 1'b0;
    data_mask_bus = 4'hF; drive_en = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_irqs", {28'd0, irqs}, 32'd0);
    bus_read("rst_level", A_LV, 32'h0);
    bus_read("rst_pend", A_PD, 32'h0);

    // 1: rising edge on channel 2 lands on the 6th edge
    bus_write(A_EN, 32'hF, 4'hF, 1);
    bus_write(A_MD, 32'h55, 4'hF, 1);
    @(posedge clk); #1 btns[2] = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("t1_irq2_edge%0d", k), {31'd0, irqs[2]}, (k >= 6) ? 32'd1 : 32'd0);
    end
    bus_read("t1_level", A_LV, 32'h4);
    bus_read("t1_pend", A_PD, 32'h4);

    // 2: short glitch ignored, full hold accepted
    @(posedge clk); #1 btns[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1 btns[0] = 1'b0;
    repeat (10) @(posedge clk);
    bus_read("t2_glitch_pend", A_PD, 32'h4);
    bus_read("t2_glitch_level", A_LV, 32'h4);
    #1 btns[0] = 1'b1;
    repeat (8) @(posedge clk);
    bus_read("t2_pend", A_PD, 32'h5);
    bus_read("t2_level", A_LV, 32'h5);
    chk("t2_irqs", {28'd0, irqs}, 32'h5);

    // 4: W1C, then clear coinciding with a new event
    bus_write(A_PD, 32'h1, 4'hF, 1);
    bus_read("t4_pend", A_PD, 32'h4);
    chk("t4_irqs", {28'd0, irqs}, 32'h4);
    bus_write(A_PD, 32'h4, 4'hF, 1);
    bus_read("t4_pend_clr", A_PD, 32'h0);
    #1 btns[2] = 1'b0;
    repeat (12) @(posedge clk);
    bus_read("t4_fall_no_ev", A_PD, 32'h0);
    @(posedge clk); #1 btns[2] = 1'b1;
    repeat (4) @(posedge clk);
    bus_write(A_PD, 32'h4, 4'hF, 1);
    bus_read("t4_set_wins", A_PD, 32'h4);

    // 3: channel 1 in falling mode
    bus_write(A_MD, 32'h59, 4'hF, 1);
    #1 btns[1] = 1'b1;
    repeat (12) @(posedge clk);
    bus_read("t3_press_pend", A_PD, 32'h4);
    bus_read("t3_press_level", A_LV, 32'h7);
    #1 btns[1] = 1'b0;
    repeat (12) @(posedge clk);
    bus_read("t3_release_pend", A_PD, 32'h6);
    bus_read("t3_release_level", A_LV, 32'h5);

    // 5: held masked write, single commit, window edges
    @(posedge clk); #1;
    addr_bus = A_EN; wdata = 32'hFFFF_FF0A; data_mask_bus = 4'b0001; drive_en = 1'b1; wr_bus = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("t5_fc_cycle%0d", k), {31'd0, fc_bus}, (k == 0) ? 32'd0 : 32'd1);
    end
    @(posedge clk); #1 wr_bus = 1'b0; drive_en = 1'b0;
    @(negedge clk);
    chk("t5_fc_after", {31'd0, fc_bus}, 32'd0);
    bus_read("t5_enable", A_EN, 32'hA);
    chk("t5_irqs", {28'd0, irqs}, 32'h2);
    bus_write(A_LV, 32'h0, 4'hF, 1);
    bus_read("t5_level_ro", A_LV, 32'h5);
    @(posedge clk); #1 addr_bus = BASE + 32'd16; rd_bus = 1'b1;
    @(negedge clk);
    chk("t5_oow_data", data_bus, 32'hFFFF_FFFF);
    chk("t5_oow_rd_fc", {31'd0, fc_bus}, 32'd0);
    @(posedge clk); #1 rd_bus = 1'b0; addr_bus = BASE - 32'd4;
    wdata = 32'hF; data_mask_bus = 4'hF; drive_en = 1'b1; wr_bus = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_oow_wr_fc", {31'd0, fc_bus}, 32'd0);
    @(posedge clk); #1 wr_bus = 1'b0; drive_en = 1'b0;
    bus_read("t5_oow_no_commit", A_EN, 32'hA);

    // 6: reset during DONE
    @(posedge clk); #1;
    addr_bus = A_EN; wdata = 32'hF; data_mask_bus = 4'hF; drive_en = 1'b1; wr_bus = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_fc_done", {31'd0, fc_bus}, 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_fc_idle", {31'd0, fc_bus}, 32'd0);
    chk("t6_irqs", {28'd0, irqs}, 32'd0);
    #1 wr_bus = 1'b0; drive_en = 1'b0;
    bus_read("t6_level", A_LV, 32'h0);
    bus_read("t6_enable", A_EN, 32'h0);
    bus_read("t6_mode", A_MD, 32'h0);
    bus_read("t6_pend", A_PD, 32'h0);
    repeat (10) @(posedge clk);
    bus_read("t6_level_held", A_LV, 32'h5);
    bus_read("t6_pend_held", A_PD, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounced_buttons_bus_interface.md
Name: debounced_buttons_bus_interface

Overview:
Parametrised successor to the fixed four-button interface.
- Serves CHANNELS button inputs, each with a 2-FF synchroniser and a counter debouncer.
- Per-channel edge-mode selection: off / rising / falling / both.
- Sticky write-1-to-clear pending flags and per-channel level IRQs, all behind one memory-mapped system-bus slave window.

Parameters:
START_ADDR, 32'h0, byte base address of the 16-byte register window (word-aligned).
CHANNELS, 4, number of button channels; legal range 1..16.
DEBOUNCE_CYCLES, 1000, consecutive stable synchronised cycles required before the debounced level changes; legal range >= 1.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  reset, synchronous and active-high.
btns  input  CHANNELS  raw asynchronous button levels.
irqs  output  CHANNELS  level interrupt per channel.
addr_bus  input  32  bus byte address.
data_bus  inout  32  bus data; driven only during a read hit, else 'z.
rd_bus  input  1  bus read strobe.
wr_bus  input  1  bus write strobe.
data_mask_bus  input  4  byte-lane write enables; bit b enables bits [8b+7:8b].
fc_bus  output  1  function-complete; driven only on an address hit, else 'z.

Behaviour:
Register map (word index = addr_bus[3:2]; addr_bus[1:0] ignored; hit when START_ADDR <= addr_bus < START_ADDR+16):
- 0 ENABLE (RW): bits [CHANNELS-1:0] are IRQ enables.
- 1 MODE (RW): bits [2i+1:2i] set the channel i edge mode: 00 off, 01 rising, 10 falling, 11 both.
- 2 LEVEL (RO): debounced levels in bits [CHANNELS-1:0]; writes are acknowledged and ignored.
- 3 PENDING (R/W1C): bits [CHANNELS-1:0]; writing 1 clears, writing 0 has no effect.
- All unimplemented bits read 0 and ignore writes.
- Writes honour data_mask_bus per byte lane; W1C applies only within enabled lanes.

Synchroniser:
- sync[i] = btns[i] delayed two flops.

Debouncer (per channel, counter width clog2(DEBOUNCE_CYCLES)+1):
- If sync == deb: counter <= 0.
- Else if counter == DEBOUNCE_CYCLES-1: deb <= sync, counter <= 0.
- Else: counter <= counter + 1.
- Net effect: deb changes on the edge completing DEBOUNCE_CYCLES consecutive cycles of sync != deb. A glitch shorter than that restarts the count from 0.
- Raw-pin-to-deb latency is 2 + DEBOUNCE_CYCLES cycles for a clean step.

Event detection:
- An event occurs on the same edge deb changes, if the mode matches: rise with mode 01/11, fall with mode 10/11.
- An event sets pending[i] on that edge.
- If an event and a W1C to the same bit occur in the same cycle, set wins (pending stays 1).
- irqs[i] = pending[i] & enable[i], combinational from registers. Disabling an enable masks the IRQ but keeps pending.

Bus handshake:
- Read: data_bus = selected register, fc_bus = 1, both combinational while addr hit && rd_bus. Zero wait states.
- Write FSM IDLE/DONE:
  - IDLE, on hit && wr_bus: commit the write, go to DONE.
  - DONE: fc_bus = 1; return to IDLE when wr_bus drops (or addr leaves the window).
- A write is committed exactly once per strobe, however long wr_bus is held.
- On a hit with no strobe, or in IDLE during a write, fc_bus = 0.

Reset (synchronous):
- Clears sync, deb, counters, enable, mode and pending; FSM goes to IDLE.
- irqs = 0 and LEVEL = 0 after reset.
- A button held high through reset produces a debounced rise DEBOUNCE_CYCLES+2 cycles later, with no pending set because mode is 00.
- Reset mid-write drops the transaction; the master must re-issue it.

Test Plan:
1. DEBOUNCE_CYCLES=4, CHANNELS=4. Write ENABLE=0xF and MODE=0x55 (all rising). Raise btns[2] -> LEVEL bit2 = 1 and irqs[2] = 1 exactly 6 cycles after the pin edge. PENDING reads 0x4.
2. Pulse btns[0] high for 3 synchronised cycles (< DEBOUNCE_CYCLES) -> LEVEL, PENDING and irqs stay 0. Then hold high for 4 cycles -> bit0 sets.
3. MODE channel1 = 10 (falling). Press then release btn1 -> no pending on press; pending bit1 set only on the debounced release.
4. With pending = 0x5, write 0x1 to PENDING -> reads 0x4, irqs[0] = 0. Write 0x4 on the exact cycle channel2 logs a new event -> bit2 remains 1.
5. Hold wr_bus 5 cycles on ENABLE with data_mask_bus = 4'b0001 and data 0xFFFF_FF0A -> only the low byte is written (ENABLE = 0xA). fc_bus = 0 on the first cycle, then 1 until wr_bus drops. Single commit. Accesses outside the window -> fc_bus and data_bus stay 'z.
6. Assert rst during DONE with pending, enable and mode all nonzero -> next cycle all registers are 0, irqs = 0, FSM is IDLE (fc_bus = 0 on the held write).
